demux8_frame_seq: RTL and testbench
===================================

Name: demux8_frame_seq

Overview:
- Upstream sequencer for the 8-way 1-to-8 demux stage.
- Accepts an 8-bit frame plus a channel-enable mask and walks the enabled channels in ascending order.
- For each enabled channel it drives the demux data bit (din) and selects (s2,s1,s0), holding each for a programmable number of cycles.
- Signals completion with a one-cycle frame_done pulse.

Parameters:
- HOLD_CYCLES, 4, cycles each channel's select/data is held stable; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new frame; sampled only in IDLE.
- frame_in  input  8  data bits; bit k is routed to channel k.
- chan_mask  input  8  bit k = 1 means channel k is visited.
- busy  output  1  high from the cycle after an accepted start until the cycle frame_done is asserted.
- din  output  1  data bit to the demux.
- s2  output  1  select MSB.
- s1  output  1  select middle bit.
- s0  output  1  select LSB.
- sel_valid  output  1  high while din/s2..s0 present a valid channel.
- frame_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous on rst high: state = IDLE; busy, din, s2, s1, s0, sel_valid, frame_done all 0; latched frame/mask = 0; hold counter = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, DRIVE, DONE.
- IDLE, start=1:
  - Latch frame_in and chan_mask.
  - If the mask is nonzero, go to DRIVE with ch = lowest set bit. In the next cycle, sel_valid=1, {s2,s1,s0}=ch, din=frame[ch], busy=1, counter=HOLD_CYCLES-1.
  - If the mask is zero, go to DONE. frame_done=1 in the next cycle; sel_valid stays 0.
- DRIVE:
  - Outputs stay stable while counter != 0; counter decrements each cycle.
  - At counter == 0, find the next set mask bit strictly above ch.
  - If one exists, load it in the same edge: the new select/din appear the next cycle with no gap, sel_valid stays 1, and counter reloads.
  - If none exists, go to DONE. sel_valid, busy and din drop to 0; the select outputs hold their last value.
- DONE: frame_done=1 for exactly one cycle, busy=0, then IDLE.
- A back-to-back start is accepted the cycle after DONE, i.e. while in IDLE.
- start while busy or in DONE: ignored. Frame and mask are not re-latched, and no queueing occurs.
- Changes on frame_in/chan_mask during a frame have no effect, because latched copies are used.
- Frame latency: start at cycle N, first sel_valid at N+1. Total cycles in DRIVE = popcount(mask) * HOLD_CYCLES. frame_done at N+1+popcount*HOLD_CYCLES.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). frame_done is not emitted. After release the block is in IDLE.
- Channel 7 is the terminal channel. No wrap-around to channel 0.

Decomposition:
- Shared package demux8_pkg:
  - state enum (IDLE, DRIVE, DONE).
  - NUM_CH = 8, SEL_W = 3.
- One sub-module: demux8_next_ch, combinational.
  - Inputs: mask[7:0], current ch[2:0], first flag.
  - Outputs: next ch[2:0], found.
  - When first=1 it returns the lowest set bit; otherwise the lowest set bit above ch.
  - Used in both IDLE and DRIVE.

Test Plan:
- Reset check: rst=1 mid-DRIVE (frame 0xFF, mask 0xFF) -> all outputs 0 in the same cycle. After release: busy=0, no frame_done.
- Full sweep: HOLD_CYCLES=4, frame 0xA5, mask 0xFF -> channels 0..7 each held 4 cycles. din sequence 1,0,1,0,0,1,0,1. frame_done exactly 33 cycles after start.
- Sparse mask: frame 0x0F, mask 0x92 -> channels 1, 4, 7 only, with din 1, 0, 0 and no sel_valid gap between channels. busy high 12 cycles.
- Zero mask: mask 0x00, start=1 -> frame_done at start+1, sel_valid never high.
- Ignored start: second start with frame 0x00 during busy -> first frame 0xFF completes unchanged, only one frame_done.
- Back-to-back: start held high continuously, mask 0x01 -> frame repeats. frame_done every HOLD_CYCLES+2 cycles; the select is always 000.

Source files
------------

// File: rtl/demux8_pkg.sv
// Shared types and constants for the 8-channel demux frame sequencer.
package demux8_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/demux8_next_ch.sv
// Combinational channel finder: lowest set mask bit, either overall (first)
// or strictly above the current channel.
module demux8_next_ch
  import demux8_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  ch,
  input  logic              first,
  output logic [SEL_W-1:0]  next_ch,
  output logic              found
);

  // Scanning downwards lets the lowest qualifying bit win.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(ch)))) begin
        next_ch = SEL_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux8_frame_seq.sv
// Frame sequencer: walks enabled channels in ascending order, holding each
// channel's select and data bit for HOLD_CYCLES cycles, then pulses frame_done.
module demux8_frame_seq
  import demux8_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  frame_in,
  input  logic [7:0]  chan_mask,
  output logic        busy,
  output logic        din,
  output logic        s2,
  output logic        s1,
  output logic        s0,
  output logic        sel_valid,
  output logic        frame_done
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]   frame_q, frame_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                busy_q, busy_d;
  logic                din_q, din_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic                first;
  logic [NUM_CH-1:0]   search_mask;
  logic [SEL_W-1:0]    nxt_ch;
  logic                nxt_found;

  // In IDLE the search runs on the live mask so the first channel loads on the accepting edge.
  assign first       = (state_q == IDLE);
  assign search_mask = first ? chan_mask : mask_q;

  demux8_next_ch u_next_ch (
    .mask    (search_mask),
    .ch      (ch_q),
    .first   (first),
    .next_ch (nxt_ch),
    .found   (nxt_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = frame_in;
          mask_d  = chan_mask;
          if (nxt_found) begin
            state_d = DRIVE;
            ch_d    = nxt_ch;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (nxt_found) begin
          ch_d  = nxt_ch;
          cnt_d = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered, one edge after the decision.
  always_comb begin
    busy_d  = (state_d == DRIVE);
    valid_d = (state_d == DRIVE);
    done_d  = (state_d == DONE);
    din_d   = (state_d == DRIVE) ? frame_d[ch_d] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      frame_q <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      din_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      din_q   <= din_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign din        = din_q;
  assign s2         = ch_q[2];
  assign s1         = ch_q[1];
  assign s0         = ch_q[0];
  assign sel_valid  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux8_frame_seq.sv
// Directed bench for demux8_frame_seq: every cycle of each frame is compared
// against hand-derived {busy,din,s2,s1,s0,sel_valid,frame_done} vectors.
module tb_demux8_frame_seq;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] frame_in;
  logic [7:0] chan_mask;
  logic       busy, din, s2, s1, s0, sel_valid, frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] sweep_din;
  logic [2:0] sp_ch  [3];
  logic       sp_din [3];

  always #5 clk = ~clk;

  demux8_frame_seq #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_in   (frame_in),
    .chan_mask  (chan_mask),
    .busy       (busy),
    .din        (din),
    .s2         (s2),
    .s1         (s1),
    .s0         (s0),
    .sel_valid  (sel_valid),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic st, input logic [7:0] fr, input logic [7:0] mk);
    start     = st;
    frame_in  = fr;
    chan_mask = mk;
  endtask

  task automatic check_output(input string tag, input logic [6:0] expected);
    logic [6:0] observed;
    observed = {busy, din, s2, s1, s0, sel_valid, frame_done};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_channel(input string tag, input logic [2:0] ch, input logic d);
    for (int h = 0; h < HOLD; h++) begin
      check_output($sformatf("%s_ch%0d_h%0d", tag, ch, h), {1'b1, d, ch, 1'b1, 1'b0});
      tick();
    end
  endtask

  initial begin
    sweep_din = 8'b1010_0101;
    sp_ch     = '{3'd1, 3'd4, 3'd7};
    sp_din    = '{1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    apply_stimulus(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    check_output("reset_state", 7'b0);
    rst = 1'b0;
    tick();
    check_output("reset_release", 7'b0);

    $display("[TB] full sweep frame=A5 mask=FF");
    apply_stimulus(1'b1, 8'hA5, 8'hFF);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00);
    for (int ch = 0; ch < 8; ch++) begin
      check_channel("sweep", 3'(ch), sweep_din[ch]);
    end
    check_output("sweep_done", {1'b0, 1'b0, 3'd7, 1'b0, 1'b1});
    tick();
    check_output("sweep_idle", {1'b0, 1'b0, 3'd7, 1'b0, 1'b0});

    $display("[TB] sparse frame=0F mask=92");
    apply_stimulus(1'b1, 8'h0F, 8'h92);
    tick();
    apply_stimulus(1'b0, 8'hF0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      check_channel("sparse", sp_ch[i], sp_din[i]);
    end
    check_output("sparse_done", {1'b0, 1'b0, 3'd7, 1'b0, 1'b1});
    tick();
    check_output("sparse_idle", {1'b0, 1'b0, 3'd7, 1'b0, 1'b0});

    $display("[TB] zero mask");
    apply_stimulus(1'b1, 8'hFF, 8'h00);
    tick();
    apply_stimulus(1'b0, 8'hFF, 8'h00);
    check_output("zero_done", {1'b0, 1'b0, 3'd7, 1'b0, 1'b1});
    tick();
    check_output("zero_idle", {1'b0, 1'b0, 3'd7, 1'b0, 1'b0});

    $display("[TB] ignored start during busy and done");
    apply_stimulus(1'b1, 8'hFF, 8'hFF);
    tick();
    for (int i = 0; i < 8 * HOLD; i++) begin
      if (i >= 2 && i < 12) apply_stimulus(1'b1, 8'h00, 8'h01);
      else                  apply_stimulus(1'b0, 8'h00, 8'h01);
      check_output($sformatf("ignore_cyc%0d", i), {1'b1, 1'b1, 3'(i / HOLD), 1'b1, 1'b0});
      tick();
    end
    check_output("ignore_done", {1'b0, 1'b0, 3'd7, 1'b0, 1'b1});
    apply_stimulus(1'b1, 8'h00, 8'h01);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h01);
    check_output("ignore_idle", {1'b0, 1'b0, 3'd7, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output($sformatf("ignore_quiet%0d", i), {1'b0, 1'b0, 3'd7, 1'b0, 1'b0});
    end

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 8'hFF, 8'hFF);
    tick();
    apply_stimulus(1'b0, 8'hFF, 8'hFF);
    tick();
    tick();
    check_output("rst_pre", {1'b1, 1'b1, 3'd0, 1'b1, 1'b0});
    tick();
    tick();
    check_output("rst_pre_ch1", {1'b1, 1'b1, 3'd1, 1'b1, 1'b0});
    #3;
    rst = 1'b1;
    #1;
    check_output("rst_async", 7'b0);
    tick();
    check_output("rst_held", 7'b0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check_output($sformatf("rst_after%0d", i), 7'b0);
    end

    $display("[TB] back-to-back mask=01");
    apply_stimulus(1'b1, 8'h01, 8'h01);
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 18) apply_stimulus(1'b0, 8'h01, 8'h01);
      case (k % (HOLD + 2))
        5:       check_output($sformatf("b2b_k%0d", k), {1'b0, 1'b0, 3'd0, 1'b0, 1'b1});
        0:       check_output($sformatf("b2b_k%0d", k), {1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        default: check_output($sformatf("b2b_k%0d", k), {1'b1, 1'b1, 3'd0, 1'b1, 1'b0});
      endcase
    end
    tick();
    check_output("b2b_stopped", {1'b0, 1'b0, 3'd0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
